// File: rtl/sync_bus_rx_if.sv
// Bus bundle for the toggle-handshake receive port: sender-side request/data,
// returned ack, and the downstream valid/ready channel.
interface sync_bus_rx_if #(
    parameter int WIDTH = 32
);
    logic             req_tgl;
    logic [WIDTH-1:0] in_data;
    logic             ack_tgl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    // Environment side: sender plus downstream consumer
    modport master (
        output req_tgl, in_data, out_ready,
        input  ack_tgl, out_valid, out_data, busy
    );

    // Receiver block side
    modport slave (
        input  req_tgl, in_data, out_ready,
        output ack_tgl, out_valid, out_data, busy
    );
endinterface

// File: rtl/sync_bus_rx.sv
// Receive end of a toggle-handshake clock-domain crossing. req_tgl is
// synchronized into clk; in_data is sampled only once the synchronized request
// differs from the last one taken, relying on the sender holding it stable.
module sync_bus_rx #(
    parameter int WIDTH     = 32,
    parameter int STAGES    = 2,
    parameter bit ACK_EARLY = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    sync_bus_rx_if.slave  bus
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_bus_rx: STAGES must be >= 2");
    end

    typedef enum logic {IDLE, FULL} state_t;

    state_t             state;
    logic [STAGES-1:0]  sync_q;
    logic               req_s;
    logic               req_seen;
    logic               pend;
    logic               accept;
    logic               ack_q;
    logic               valid_q;
    logic [WIDTH-1:0]   data_q;

    assign req_s  = sync_q[STAGES-1];
    assign pend   = (req_s != req_seen);
    assign accept = valid_q & bus.out_ready;

    assign bus.ack_tgl   = ack_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.busy      = valid_q | pend;

    // Multi-flop synchronizer for the request level; only the last stage is used
    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[STAGES-2:0], bus.req_tgl};
    end

    // Capture / hold / ack state machine
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            req_seen <= 1'b0;
            ack_q    <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pend) begin
                        data_q   <= bus.in_data;
                        req_seen <= req_s;
                        valid_q  <= 1'b1;
                        state    <= FULL;
                        if (ACK_EARLY) ack_q <= req_s;
                    end
                end
                FULL: begin
                    if (accept) begin
                        if (ACK_EARLY && pend) begin
                            // Early-ack sender already has the next word up:
                            // swap it in on the accept edge, no bubble.
                            data_q   <= bus.in_data;
                            req_seen <= req_s;
                            ack_q    <= req_s;
                        end else begin
                            if (!ACK_EARLY) ack_q <= req_seen;
                            valid_q <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_bus_rx.sv
// Bench for sync_bus_rx: one late-ack (ACK_EARLY=0) and one early-ack
// (ACK_EARLY=1) instance, a vector table for the basic handshake and
// hand-written sequences for backpressure, reset and a streaming run.
module tb_sync_bus_rx;

    logic clk = 1'b0;
    logic rst0, rst1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sync_bus_rx_if #(.WIDTH(32)) if0 ();
    sync_bus_rx_if #(.WIDTH(32)) if1 ();

    sync_bus_rx #(.WIDTH(32), .STAGES(2), .ACK_EARLY(1'b0)) u0 (
        .clk(clk), .reset(rst0), .bus(if0.slave));
    sync_bus_rx #(.WIDTH(32), .STAGES(2), .ACK_EARLY(1'b1)) u1 (
        .clk(clk), .reset(rst1), .bus(if1.slave));

    typedef struct {
        logic        req;
        logic [31:0] data;
        logic        rdy;
        int          reps;
        logic        vld;
        logic [31:0] odat;
        logic        ack;
        logic        busy;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [2:0] ash;
        logic       ack_prev;
        int         sent, got, togs;

        // Late-ack handshake: capture STAGES edges after the toggle, ack on accept
        tbl[0] = '{1'b1, 32'hA5A5_0001, 1'b1, 1,  1'b0, 32'h0,         1'b0, 1'b0};
        tbl[1] = '{1'b1, 32'hA5A5_0001, 1'b1, 1,  1'b0, 32'h0,         1'b0, 1'b1};
        tbl[2] = '{1'b1, 32'hA5A5_0001, 1'b1, 1,  1'b1, 32'hA5A5_0001, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 32'hA5A5_0001, 1'b1, 1,  1'b0, 32'hA5A5_0001, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 32'hA5A5_0001, 1'b1, 2,  1'b0, 32'hA5A5_0001, 1'b1, 1'b0};
        // Backpressure: 20 cycles stalled, data frozen, no ack until accept
        tbl[5] = '{1'b0, 32'h1234_5678, 1'b0, 1,  1'b0, 32'hA5A5_0001, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 32'h1234_5678, 1'b0, 1,  1'b0, 32'hA5A5_0001, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 32'h1234_5678, 1'b0, 1,  1'b1, 32'h1234_5678, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 32'hDEAD_BEEF, 1'b0, 20, 1'b1, 32'h1234_5678, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 32'hDEAD_BEEF, 1'b1, 1,  1'b0, 32'h1234_5678, 1'b0, 1'b0};

        if0.req_tgl = 1'b0; if0.in_data = '0; if0.out_ready = 1'b1;
        if1.req_tgl = 1'b0; if1.in_data = '0; if1.out_ready = 1'b0;
        rst0 = 1'b1; rst1 = 1'b1;

        // Reset state, then 10 idle cycles
        step(3);
        rst0 = 1'b0; rst1 = 1'b0;
        step(10);
        chk("rst_valid0", {31'd0, if0.out_valid}, 32'd0);
        chk("rst_ack0",   {31'd0, if0.ack_tgl},   32'd0);
        chk("rst_busy0",  {31'd0, if0.busy},      32'd0);
        chk("rst_data0",  if0.out_data,           32'd0);
        chk("rst_valid1", {31'd0, if1.out_valid}, 32'd0);
        chk("rst_ack1",   {31'd0, if1.ack_tgl},   32'd0);

        // Table run on the late-ack instance: one edge per repetition
        for (int i = 0; i < 10; i++) begin
            if0.req_tgl   = tbl[i].req;
            if0.in_data   = tbl[i].data;
            if0.out_ready = tbl[i].rdy;
            for (int r = 0; r < tbl[i].reps; r++) begin
                step(1);
                chk($sformatf("v%0d_valid", i), {31'd0, if0.out_valid}, {31'd0, tbl[i].vld});
                chk($sformatf("v%0d_data", i),  if0.out_data,           tbl[i].odat);
                chk($sformatf("v%0d_ack", i),   {31'd0, if0.ack_tgl},   {31'd0, tbl[i].ack});
                chk($sformatf("v%0d_busy", i),  {31'd0, if0.busy},      {31'd0, tbl[i].busy});
            end
        end

        // Early ack: second request waits behind a stalled word, then swaps in
        if1.out_ready = 1'b0;
        if1.req_tgl = 1'b1; if1.in_data = 32'h0000_1111;
        step(2);
        chk("e1_valid_k1", {31'd0, if1.out_valid}, 32'd0);
        step(1);
        chk("e1_valid", {31'd0, if1.out_valid}, 32'd1);
        chk("e1_data",  if1.out_data,           32'h0000_1111);
        chk("e1_ack",   {31'd0, if1.ack_tgl},   32'd1);
        if1.req_tgl = 1'b0; if1.in_data = 32'h0000_2222;
        step(5);
        chk("e2_hold_valid", {31'd0, if1.out_valid}, 32'd1);
        chk("e2_hold_data",  if1.out_data,           32'h0000_1111);
        chk("e2_hold_ack",   {31'd0, if1.ack_tgl},   32'd1);
        chk("e2_hold_busy",  {31'd0, if1.busy},      32'd1);
        if1.out_ready = 1'b1;
        step(1);
        chk("e2_swap_valid", {31'd0, if1.out_valid}, 32'd1);
        chk("e2_swap_data",  if1.out_data,           32'h0000_2222);
        chk("e2_swap_ack",   {31'd0, if1.ack_tgl},   32'd0);
        step(1);
        chk("e2_drain_valid", {31'd0, if1.out_valid}, 32'd0);
        chk("e2_drain_busy",  {31'd0, if1.busy},      32'd0);

        // Reset while FULL with a pending request, then recapture
        if1.out_ready = 1'b0;
        if1.req_tgl = 1'b1; if1.in_data = 32'h0000_3333;
        step(3);
        chk("r_full_data", if1.out_data, 32'h0000_3333);
        if1.req_tgl = 1'b0; if1.in_data = 32'h0000_4444;
        step(3);
        chk("r_pend_busy", {31'd0, if1.busy},      32'd1);
        chk("r_pend_data", if1.out_data,           32'h0000_3333);
        rst1 = 1'b1;
        if1.req_tgl = 1'b1; if1.in_data = 32'h0000_5555;
        step(1);
        chk("r_valid", {31'd0, if1.out_valid}, 32'd0);
        chk("r_ack",   {31'd0, if1.ack_tgl},   32'd0);
        chk("r_data",  if1.out_data,           32'd0);
        rst1 = 1'b0;
        step(2);
        chk("r_recap_early", {31'd0, if1.out_valid}, 32'd0);
        step(1);
        chk("r_recap_valid", {31'd0, if1.out_valid}, 32'd1);
        chk("r_recap_data",  if1.out_data,           32'h0000_5555);
        chk("r_recap_ack",   {31'd0, if1.ack_tgl},   32'd1);

        // Streaming: 256 words, sender sees ack through 3 flops, random ready
        rst1 = 1'b1; if1.req_tgl = 1'b0; if1.in_data = '0; if1.out_ready = 1'b0;
        step(2);
        rst1 = 1'b0;
        ash = '0; ack_prev = 1'b0; sent = 0; got = 0; togs = 0;
        for (int cyc = 0; cyc < 20000 && (got < 256 || togs < 256); cyc++) begin
            @(negedge clk);
            if (if1.ack_tgl != ack_prev) togs++;
            ack_prev = if1.ack_tgl;
            if1.out_ready = $urandom_range(0, 1) == 1;
            if (if1.out_valid && if1.out_ready) begin
                if (if1.out_data !== got) begin
                    errors++;
                    $display("FAIL stream_word: got %0d expected %0d", if1.out_data, got);
                end
                got++;
            end
            ash = {ash[1:0], if1.ack_tgl};
            if (sent < 256 && ash[2] == if1.req_tgl) begin
                if1.in_data = sent;
                if1.req_tgl = ~if1.req_tgl;
                sent++;
            end
        end
        chk("stream_count", got,  32'd256);
        chk("stream_acks",  togs, 32'd256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
